// File: rtl/boot_copy_master.sv
// Avalon-MM word-copy master: moves i_Count words from i_SrcAddr to i_DstAddr, one read/write pair per word.
// Optional running checksum of written words is built when BOOT_COPY_CHECKSUM_EN is defined.
module boot_copy_master #(
    parameter int COUNT_W = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Start,
    input  logic [29:0]        i_SrcAddr,
    input  logic [29:0]        i_DstAddr,
    input  logic [COUNT_W-1:0] i_Count,
    output logic               o_Busy,
    output logic               o_Done,
    output logic [31:0]        o_Checksum,
    output logic [29:0]        o_AV_Addr,
    output logic               o_AV_Read,
    output logic               o_AV_Write,
    output logic [31:0]        o_AV_WriteData,
    input  logic [31:0]        i_AV_ReadData,
    input  logic               i_AV_WaitRequest
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RLAT,
        WR,
        FIN
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [29:0]        src_reg;
    logic [29:0]        dst_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [31:0]        data_reg;

    logic start_accept;
    logic write_accept;

    assign start_accept = (state_reg == IDLE) && i_Start;
    assign write_accept = (state_reg == WR) && !i_AV_WaitRequest;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            count_reg <= '0;
            data_reg  <= '0;
        end else begin
            if (start_accept) begin
                src_reg   <= i_SrcAddr;
                dst_reg   <= i_DstAddr;
                count_reg <= i_Count;
            end
            // Read data is only meaningful in the cycle after read acceptance.
            if (state_reg == RLAT) begin
                data_reg <= i_AV_ReadData;
            end
            if (write_accept) begin
                src_reg   <= src_reg + 30'd1;
                dst_reg   <= dst_reg + 30'd1;
                count_reg <= count_reg - COUNT_W'(1);
            end
        end
    end

`ifdef BOOT_COPY_CHECKSUM_EN
    logic [31:0] sum_reg;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sum_reg <= '0;
        end else if (start_accept) begin
            sum_reg <= '0;
        end else if (write_accept) begin
            sum_reg <= sum_reg + data_reg;
        end
    end

    assign o_Checksum = sum_reg;
`else
    assign o_Checksum = '0;
`endif

    always_comb begin
        state_next     = state_reg;
        o_AV_Read      = 1'b0;
        o_AV_Write     = 1'b0;
        o_AV_Addr      = '0;
        o_AV_WriteData = '0;
        o_Busy         = 1'b0;
        o_Done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_Start) begin
                    state_next = (i_Count == '0) ? FIN : RD;
                end
            end
            RD: begin
                o_Busy    = 1'b1;
                o_AV_Read = 1'b1;
                o_AV_Addr = src_reg;
                if (!i_AV_WaitRequest) begin
                    state_next = RLAT;
                end
            end
            RLAT: begin
                o_Busy     = 1'b1;
                state_next = WR;
            end
            WR: begin
                o_Busy         = 1'b1;
                o_AV_Write     = 1'b1;
                o_AV_Addr      = dst_reg;
                o_AV_WriteData = data_reg;
                // count_reg is still the pre-decrement value here.
                if (!i_AV_WaitRequest) begin
                    state_next = (count_reg == COUNT_W'(1)) ? FIN : RD;
                end
            end
            FIN: begin
                o_Done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_copy_master.sv
// Directed bench for boot_copy_master: table of copies plus stall, reset and mid-copy-start sequences.
// Expected checksums follow BOOT_COPY_CHECKSUM_EN the same way the design does.
module tb_boot_copy_master;

    logic        clk = 1'b0;
    logic        i_Rst;
    logic        i_Start;
    logic [29:0] i_SrcAddr;
    logic [29:0] i_DstAddr;
    logic [15:0] i_Count;
    logic        o_Busy;
    logic        o_Done;
    logic [31:0] o_Checksum;
    logic [29:0] o_AV_Addr;
    logic        o_AV_Read;
    logic        o_AV_Write;
    logic [31:0] o_AV_WriteData;
    logic [31:0] i_AV_ReadData;
    logic        i_AV_WaitRequest;

    always #5 clk = ~clk;

    boot_copy_master #(.COUNT_W(16)) dut (
        .i_Clk           (clk),
        .i_Rst           (i_Rst),
        .i_Start         (i_Start),
        .i_SrcAddr       (i_SrcAddr),
        .i_DstAddr       (i_DstAddr),
        .i_Count         (i_Count),
        .o_Busy          (o_Busy),
        .o_Done          (o_Done),
        .o_Checksum      (o_Checksum),
        .o_AV_Addr       (o_AV_Addr),
        .o_AV_Read       (o_AV_Read),
        .o_AV_Write      (o_AV_Write),
        .o_AV_WriteData  (o_AV_WriteData),
        .i_AV_ReadData   (i_AV_ReadData),
        .i_AV_WaitRequest(i_AV_WaitRequest)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [29:0] rd_q[$];
    logic [29:0] wr_q[$];
    logic [31:0] wd_q[$];
    int done_count = 0;
    int done_off = 0;
    int both_viol = 0;
    int idle_addr_viol = 0;
    int hold_viol = 0;
    int stall_obs = 0;
    int rd_stall_left = 0;
    int wr_stall_left = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_bus = '0;
    logic        rd_pend = 1'b0;
    logic [29:0] rd_pend_addr = '0;

    function automatic logic [31:0] slave_word(input logic [29:0] a);
        case (a)
            30'd0:   return 32'hA00000B7;
            30'd1:   return 32'h00008023;
            30'd2:   return 32'h00000001;
            30'd3:   return 32'h00000010;
            30'd4:   return 32'h00000100;
            30'd5:   return 32'h00001000;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef BOOT_COPY_CHECKSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_AV_Read && o_AV_Write) both_viol++;
        if (!o_AV_Read && !o_AV_Write && o_AV_Addr != 30'd0) idle_addr_viol++;
        if (prev_stall && !i_Rst
            && {o_AV_Read, o_AV_Write, o_AV_Addr, o_AV_WriteData} != prev_bus) hold_viol++;
        prev_stall = i_AV_WaitRequest && (o_AV_Read || o_AV_Write);
        prev_bus   = {o_AV_Read, o_AV_Write, o_AV_Addr, o_AV_WriteData};
        if (prev_stall) stall_obs++;
        rd_pend      = o_AV_Read && !i_AV_WaitRequest && !i_Rst;
        rd_pend_addr = o_AV_Addr;
        if (o_AV_Read && !i_AV_WaitRequest) rd_q.push_back(o_AV_Addr);
        if (o_AV_Write && !i_AV_WaitRequest) begin
            wr_q.push_back(o_AV_Addr);
            wd_q.push_back(o_AV_WriteData);
        end
        if (o_Done) begin
            done_count++;
            done_off = int'(cyc - start_cyc) + 1;
        end
    end

    // Slave: returns data one cycle after read acceptance, junk otherwise; inserts requested stalls.
    always @(posedge clk) begin
        logic        acc;
        logic [29:0] a;
        acc = rd_pend;
        a   = rd_pend_addr;
        #2;
        i_AV_ReadData = acc ? slave_word(a) : (32'hBAD00000 | {16'h0, cyc[15:0]});
        if (i_Rst) begin
            i_AV_WaitRequest = 1'b0;
        end else if (o_AV_Read && rd_stall_left > 0) begin
            i_AV_WaitRequest = 1'b1;
            rd_stall_left--;
        end else if (o_AV_Write && wr_stall_left > 0) begin
            i_AV_WaitRequest = 1'b1;
            wr_stall_left--;
        end else begin
            i_AV_WaitRequest = 1'b0;
        end
    end

    task automatic clear_log();
        rd_q.delete();
        wr_q.delete();
        wd_q.delete();
        done_count = 0;
        done_off   = -1;
        stall_obs  = 0;
    endtask

    task automatic start_copy(input logic [29:0] src, input logic [29:0] dst, input logic [15:0] cnt);
        @(posedge clk);
        #2;
        i_SrcAddr = src;
        i_DstAddr = dst;
        i_Count   = cnt;
        i_Start   = 1'b1;
        @(posedge clk);
        #2;
        start_cyc = cyc;
        i_Start   = 1'b0;
    endtask

    task automatic run_copy(input string tag, input logic [29:0] src, input logic [29:0] dst,
                            input logic [15:0] cnt, input int rs, input int ws, input bit glitch,
                            input int exp_done, input logic [31:0] exp_sum);
        bit seen;
        clear_log();
        rd_stall_left = rs;
        wr_stall_left = ws;
        start_copy(src, dst, cnt);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (glitch && i == 4) begin
                i_Start   = 1'b1;
                i_SrcAddr = 30'h123;
                i_DstAddr = 30'h456;
                i_Count   = 16'd9;
            end
            if (glitch && i == 5) i_Start = 1'b0;
            if (done_count != 0) begin
                seen = 1'b1;
                break;
            end
        end
        i_Start = 1'b0;
        chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_count, 32'd1);
        chk({tag, "_done_cycle"}, done_off, exp_done);
        chk({tag, "_reads"}, rd_q.size(), {16'h0, cnt});
        chk({tag, "_writes"}, wr_q.size(), {16'h0, cnt});
        for (int i = 0; i < int'(cnt) && i < rd_q.size() && i < wr_q.size(); i++) begin
            logic [29:0] sa;
            logic [29:0] da;
            sa = src + 30'(i);
            da = dst + 30'(i);
            chk($sformatf("%s_rd_addr%0d", tag, i), {2'b0, rd_q[i]}, {2'b0, sa});
            chk($sformatf("%s_wr_addr%0d", tag, i), {2'b0, wr_q[i]}, {2'b0, da});
            chk($sformatf("%s_wr_data%0d", tag, i), wd_q[i], slave_word(sa));
        end
        chk({tag, "_checksum"}, o_Checksum, exp_ck(exp_sum));
        chk({tag, "_busy_after"}, {31'h0, o_Busy}, 32'h0);
        if (rs + ws > 0) chk({tag, "_stall_cycles"}, stall_obs, rs + ws);
        $display("copy %s src=%h dst=%h cnt=%0d done@N+%0d reads=%0d writes=%0d checksum=%h",
                 tag, src, dst, cnt, done_off, rd_q.size(), wr_q.size(), o_Checksum);
    endtask

    typedef struct {
        string       name;
        logic [29:0] src;
        logic [29:0] dst;
        logic [15:0] cnt;
        int          exp_done;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit found;
        vecs[0] = '{"six_words",  30'h0,        30'h100,      16'd6, 19, 32'hA00091EB};
        vecs[1] = '{"zero_count", 30'h0,        30'h200,      16'd0, 1,  32'h00000000};
        vecs[2] = '{"src_wrap",   30'h3FFFFFFF, 30'h10,       16'd2, 7,  32'h60DF00B6};
        vecs[3] = '{"dst_wrap",   30'h20,       30'h3FFFFFFE, 16'd3, 10, 32'h429A0063};
        vecs[4] = '{"one_word",   30'h5,        30'h7,        16'd1, 4,  32'h00001000};

        i_Rst = 1'b1;
        i_Start = 1'b0;
        i_SrcAddr = '0;
        i_DstAddr = '0;
        i_Count = '0;
        i_AV_ReadData = '0;
        i_AV_WaitRequest = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, o_Busy}, 32'h0);
        chk("rst_done", {31'h0, o_Done}, 32'h0);
        chk("rst_checksum", o_Checksum, 32'h0);
        chk("rst_bus", {o_AV_Read, o_AV_Write, o_AV_Addr}, 32'h0);
        chk("rst_wdata", o_AV_WriteData, 32'h0);
        @(posedge clk);
        #2;
        i_Rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'h0, o_Busy}, 32'h0);
        chk("idle_bus", {o_AV_Read, o_AV_Write, o_AV_Addr}, 32'h0);

        for (int v = 0; v < 5; v++) begin
            run_copy(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].cnt, 0, 0, 1'b0,
                     vecs[v].exp_done, vecs[v].exp_sum);
        end

        // Stalls: 3 cycles on the read, 2 on the write -> done 5 cycles later than N+4.
        run_copy("stalled", 30'h3, 30'h50, 16'd1, 3, 2, 1'b0, 9, 32'h00000010);

        // Start pulsed with new inputs mid-copy must not disturb the running copy.
        run_copy("mid_start", 30'h0, 30'h100, 16'd6, 0, 0, 1'b1, 19, 32'hA00091EB);

        // Asynchronous reset in the second write of a 4-word copy.
        clear_log();
        start_copy(30'h40, 30'h300, 16'd4);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (o_AV_Write && wr_q.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_wr2", {31'h0, found}, 32'h1);
        i_Rst = 1'b1;
        #1;
        chk("rst_mid_read", {31'h0, o_AV_Read}, 32'h0);
        chk("rst_mid_write", {31'h0, o_AV_Write}, 32'h0);
        chk("rst_mid_addr", {2'b0, o_AV_Addr}, 32'h0);
        chk("rst_mid_wdata", o_AV_WriteData, 32'h0);
        chk("rst_mid_busy", {31'h0, o_Busy}, 32'h0);
        chk("rst_mid_checksum", o_Checksum, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        i_Rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("rst_mid_no_done", done_count, 32'h0);
        chk("rst_mid_reads", rd_q.size(), 32'd2);
        $display("copy reset_abort src=%h dst=%h cnt=4 reads=%0d done_pulses=%0d",
                 30'h40, 30'h300, rd_q.size(), done_count);
        run_copy("after_rst", 30'h1, 30'h80, 16'd2, 0, 0, 1'b0, 7, 32'h00008024);

        chk("never_both_req", both_viol, 32'h0);
        chk("idle_addr_zero", idle_addr_viol, 32'h0);
        chk("stall_hold", hold_viol, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
